sync_fifo_16x16: RTL and testbench

SYNC_FIFO_16X16 -- requirements
Module: sync_fifo_16x16

---
 rtl/sync_fifo_16x16.sv | 104 ++++++++++
 tb/tb_sync_fifo_16x16.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_16x16.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_16x16
//  Description : Addressed single-clock buffer with occupancy tracking.
//                Writers and readers supply explicit storage addresses; an
//                occupancy counter gates acceptance and drives empty/full.
//                Read data is registered (1-cycle latency, read-before-write).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_16x16 #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int RAM_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_cs,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] address_to_write,
    input  logic                  rd_cs,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] address_to_read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    // Counter spans 0..RAM_DEPTH, hence one bit wider than the address.
    localparam logic [ADDR_WIDTH:0] c_FULL_COUNT  = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_EMPTY_COUNT = '0;
    localparam logic [ADDR_WIDTH:0] c_ONE         = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Storage array; intentionally never cleared by reset.
    logic [DATA_WIDTH-1:0] r_mem [0:RAM_DEPTH-1];

    logic [ADDR_WIDTH:0]   r_count_q;
    logic [ADDR_WIDTH:0]   w_count_d;
    logic [DATA_WIDTH-1:0] r_data_out_q;
    logic [DATA_WIDTH-1:0] w_data_out_d;

    logic w_wr_req;
    logic w_rd_req;
    logic w_wr_accept;
    logic w_rd_accept;
    logic w_empty;
    logic w_full;

    // Flags decode straight from the registered counter, so they only move
    // at clock edges and cannot glitch between them.
    assign w_empty = (r_count_q == c_EMPTY_COUNT);
    assign w_full  = (r_count_q == c_FULL_COUNT);

    // Acceptance uses the pre-edge flags only: a read in the same cycle does
    // not make room for a write while full, nor does a write feed a read
    // while empty.
    assign w_wr_req    = wr_cs & wr_en;
    assign w_rd_req    = rd_cs & rd_en;
    assign w_wr_accept = w_wr_req & ~w_full;
    assign w_rd_accept = w_rd_req & ~w_empty;

    // Next occupancy: +1 write only, -1 read only, hold for both or neither.
    always_comb begin
        w_count_d = r_count_q;
        if (w_wr_accept && !w_rd_accept) begin
            w_count_d = r_count_q + c_ONE;
        end else if (w_rd_accept && !w_wr_accept) begin
            w_count_d = r_count_q - c_ONE;
        end
    end

    // Next read data: load addressed word on an accepted read, else hold.
    always_comb begin
        w_data_out_d = r_data_out_q;
        if (w_rd_accept) begin
            w_data_out_d = r_mem[address_to_read];
        end
    end

    // Control state with synchronous reset taking priority over requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q    <= '0;
            r_data_out_q <= '0;
        end else begin
            r_count_q    <= w_count_d;
            r_data_out_q <= w_data_out_d;
        end
    end

    // Storage write; the read above samples the old word on a same-address
    // collision because both use the pre-edge array contents.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_accept) begin
            r_mem[address_to_write] <= data_in;
        end
    end

    assign data_out = r_data_out_q;
    assign empty    = w_empty;
    assign full     = w_full;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_16x16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_16x16
//  Description : Self-checking bench for sync_fifo_16x16 using a reference
//                occupancy/storage model and a read-data scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_16x16;

    logic        clk;
    logic        rst;
    logic        wr_cs;
    logic        wr_en;
    logic [15:0] data_in;
    logic [3:0]  address_to_write;
    logic        rd_cs;
    logic        rd_en;
    logic [3:0]  address_to_read;
    logic [15:0] data_out;
    logic        empty;
    logic        full;

    int checks_q;
    int errors_q;

    // Reference model state
    logic [15:0] m_mem [0:15];
    int          m_count;
    logic [15:0] m_dout;
    logic [15:0] exp_q [$];

    sync_fifo_16x16 #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .RAM_DEPTH  (16)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .wr_cs            (wr_cs),
        .wr_en            (wr_en),
        .data_in          (data_in),
        .address_to_write (address_to_write),
        .rd_cs            (rd_cs),
        .rd_en            (rd_en),
        .address_to_read  (address_to_read),
        .data_out         (data_out),
        .empty            (empty),
        .full             (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_q++;
        if (obs !== exp) begin
            errors_q++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; model predicts acceptance from pre-edge count,
    // pushes expected read data at issue and pops it after the edge.
    task automatic do_cycle(input logic r,
                            input logic wcs, input logic wen,
                            input logic [15:0] wd, input logic [3:0] wa,
                            input logic rcs, input logic ren,
                            input logic [3:0] ra, input string tag);
        logic wacc;
        logic racc;
        wacc = wcs && wen && (m_count != 16) && !r;
        racc = rcs && ren && (m_count != 0) && !r;
        rst              = r;
        wr_cs            = wcs;
        wr_en            = wen;
        data_in          = wd;
        address_to_write = wa;
        rd_cs            = rcs;
        rd_en            = ren;
        address_to_read  = ra;
        if (racc) exp_q.push_back(m_mem[ra]);
        @(posedge clk);
        #1;
        if (r) begin
            m_count = 0;
            m_dout  = 16'h0000;
        end else begin
            if (wacc) m_mem[wa] = wd;
            if (wacc && !racc) m_count++;
            if (racc && !wacc) m_count--;
            if (racc) begin
                if (exp_q.size() == 0) begin
                    errors_q++;
                    $display("FAIL %s_sb: scoreboard underflow", tag);
                end else begin
                    m_dout = exp_q.pop_front();
                end
            end
        end
        check_eq({tag, "_dout"},  {16'h0, data_out}, {16'h0, m_dout});
        check_eq({tag, "_empty"}, {31'h0, empty},    {31'h0, (m_count == 0)});
        check_eq({tag, "_full"},  {31'h0, full},     {31'h0, (m_count == 16)});
        rst   = 1'b0;
        wr_cs = 1'b0;
        wr_en = 1'b0;
        rd_cs = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [15:0] d, input logic [3:0] a, input string tag);
        do_cycle(1'b0, 1'b1, 1'b1, d, a, 1'b0, 1'b0, 4'h0, tag);
    endtask

    task automatic rd(input logic [3:0] a, input string tag);
        do_cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b1, a, tag);
    endtask

    initial begin
        checks_q = 0;
        errors_q = 0;
        m_count  = 0;
        m_dout   = 16'h0;
        rst = 1'b0; wr_cs = 1'b0; wr_en = 1'b0; data_in = '0;
        address_to_write = '0; rd_cs = 1'b0; rd_en = 1'b0; address_to_read = '0;

        // Reset
        do_cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 4'h0, "reset");
        check_eq("reset_empty_abs", {31'h0, empty}, 32'd1);
        check_eq("reset_full_abs",  {31'h0, full},  32'd0);
        check_eq("reset_dout_abs",  {16'h0, data_out}, 32'd0);

        // Fill: 17 writes, the last rejected (address 16 wraps to 0)
        for (int i = 0; i < 17; i++) begin
            logic [4:0] a5;
            a5 = 5'(i);
            wr(16'(i + 1), a5[3:0], $sformatf("fill%0d", i));
        end
        check_eq("fill_full_abs", {31'h0, full}, 32'd1);

        // Drain: 17 reads; storage[0] must still hold 1
        for (int i = 0; i < 17; i++) begin
            logic [4:0] a5;
            a5 = 5'(i);
            rd(a5[3:0], $sformatf("drain%0d", i));
        end
        check_eq("drain_hold_abs",  {16'h0, data_out}, 32'd16);
        check_eq("drain_empty_abs", {31'h0, empty},    32'd1);

        // Chip-select gating: enable high, select low
        do_cycle(1'b0, 1'b0, 1'b1, 16'hBEEF, 4'h2, 1'b0, 1'b0, 4'h0, "wcs_gate");
        wr(16'hA5A5, 4'h2, "gate_prep");
        do_cycle(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 4'h2, "rcs_gate");
        do_cycle(1'b0, 1'b1, 1'b0, 16'h1111, 4'h2, 1'b1, 1'b0, 4'h2, "en_gate");
        rd(4'h2, "gate_rd");

        // Occupancy 8, then simultaneous read/write, incl. same-address
        for (int i = 0; i < 8; i++) begin
            logic [3:0] a4;
            a4 = 4'(i);
            wr(16'h0100 + 16'(i), a4, $sformatf("occ8_%0d", i));
        end
        do_cycle(1'b0, 1'b1, 1'b1, 16'h0200, 4'h8, 1'b1, 1'b1, 4'h0, "sim8");
        do_cycle(1'b0, 1'b1, 1'b1, 16'h0300, 4'h5, 1'b1, 1'b1, 4'h5, "rbw");
        check_eq("rbw_old_abs", {16'h0, data_out}, 32'h0105);

        // Top up to full, then both requested: read wins, write rejected
        for (int i = 0; i < 8; i++) begin
            logic [3:0] a4;
            a4 = 4'(9 + i);
            wr(16'h0400 + 16'(i), a4, $sformatf("top%0d", i));
        end
        do_cycle(1'b0, 1'b1, 1'b1, 16'hDEAD, 4'h3, 1'b1, 1'b1, 4'h3, "simfull");
        check_eq("simfull_full_abs", {31'h0, full}, 32'd0);
        rd(4'h3, "simfull_chk");
        wr(16'h0555, 4'h1, "refill1");
        wr(16'h0556, 4'h2, "refill2");
        wr(16'h0557, 4'h4, "refill_rej");

        // Reset mid-operation at occupancy 5 with a concurrent write
        do_cycle(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 4'h0, "rst2");
        for (int i = 0; i < 5; i++) begin
            logic [3:0] a4;
            a4 = 4'(i);
            wr(16'h0700 + 16'(i), a4, $sformatf("occ5_%0d", i));
        end
        do_cycle(1'b1, 1'b1, 1'b1, 16'hCAFE, 4'hA, 1'b0, 1'b0, 4'h0, "rstmid");
        check_eq("rstmid_empty_abs", {31'h0, empty}, 32'd1);
        wr(16'h0800, 4'h0, "post_rst_wr");
        rd(4'hA, "post_rst_rd");

        $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
        $finish;
    end

endmodule
`default_nettype wire
